// File: rtl/scarv_cop_cprs_wipe.sv
// COP general purpose register file: NRD combinational read ports, one byte-masked
// write port, optional write-to-read bypass and a one-register-per-cycle secure wipe.
module scarv_cop_cprs_wipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 3,
  parameter int BYPASS = 0,
  localparam int AW    = $clog2(NREGS),
  localparam int BW    = XLEN / 8
) (
  input  logic                g_clk,
  input  logic                g_reset,
  output logic                g_clk_req,
  input  logic [NRD-1:0]      crs_ren,
  input  logic [NRD*AW-1:0]   crs_addr,
  output logic [NRD*XLEN-1:0] crs_rdata,
  input  logic [BW-1:0]       crd_wen,
  input  logic [AW-1:0]       crd_addr,
  input  logic [XLEN-1:0]     crd_wdata,
  input  logic                wipe_req,
  output logic                wipe_busy,
  output logic                wipe_done
);

  typedef enum logic {S_IDLE, S_WIPE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] wmask;
  logic            wr_accept;
  logic            cnt_last;

  always_comb begin
    for (int b = 0; b < BW; b++) wmask[8*b +: 8] = {8{crd_wen[b]}};
  end

  // A write racing a wipe request loses so the wipe always starts from a known state.
  assign wr_accept = (|crd_wen) && (int'(crd_addr) < NREGS)
                     && (state_q == S_IDLE) && !wipe_req;
  assign cnt_last  = (cnt_q == AW'(NREGS - 1));

  assign wipe_busy = (state_q == S_WIPE);
  assign wipe_done = wipe_busy && cnt_last;
  assign g_clk_req = (|crd_wen) | wipe_req | wipe_busy;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (wipe_req) begin
          state_d = S_WIPE;
          cnt_d   = '0;
        end
      end
      S_WIPE: begin
        if (cnt_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_accept)
      regs_d[crd_addr] = (regs_q[crd_addr] & ~wmask) | (crd_wdata & wmask);
    if (state_q == S_WIPE)
      regs_d[cnt_q] = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      // NOTE: the array is reset explicitly because stale secrets must never
      // survive a reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;

    assign rd_addr = crs_addr[p*AW +: AW];

    always_comb begin
      rd_data = '0;
      if (crs_ren[p] && (int'(rd_addr) < NREGS) && !wipe_busy) begin
        rd_data = regs_q[rd_addr];
        if ((BYPASS != 0) && wr_accept && (rd_addr == crd_addr))
          rd_data = (rd_data & ~wmask) | (crd_wdata & wmask);
      end
    end

    assign crs_rdata[p*XLEN +: XLEN] = rd_data;
  end

endmodule

// File: tb/tb_scarv_cop_cprs_wipe.sv
// Scoreboard bench: a non-bypass and a bypass instance share all stimulus; a
// behavioural model predicts read data, which is queued and drained against both.
module tb_scarv_cop_cprs_wipe;

  localparam int XLEN = 32;
  localparam int NREGS = 16;
  localparam int NRD = 3;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic [2:0]  ren;
  logic [11:0] raddr;
  logic [3:0]  wen;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        wipe_req;

  logic        clk_req, clk_req_bp;
  logic [95:0] rdata, rdata_bp;
  logic        busy, busy_bp, done, done_bp;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          port;
    bit          bp;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [31:0] mreg[NREGS];
  bit          mbusy;
  int          mcnt;

  scarv_cop_cprs_wipe #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(clk_req),
    .crs_ren(ren), .crs_addr(raddr), .crs_rdata(rdata),
    .crd_wen(wen), .crd_addr(waddr), .crd_wdata(wdata),
    .wipe_req(wipe_req), .wipe_busy(busy), .wipe_done(done)
  );

  scarv_cop_cprs_wipe #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_bp (
    .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(clk_req_bp),
    .crs_ren(ren), .crs_addr(raddr), .crs_rdata(rdata_bp),
    .crd_wen(wen), .crd_addr(waddr), .crd_wdata(wdata),
    .wipe_req(wipe_req), .wipe_busy(busy_bp), .wipe_done(done_bp)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lane_mask(input logic [3:0] w);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{w[b]}};
    return m;
  endfunction

  function automatic bit m_accept();
    return (wen != 4'h0) && !mbusy && !wipe_req;
  endfunction

  function automatic logic [31:0] m_read(input int p, input bit bp);
    logic [3:0]  a;
    logic [31:0] v;
    a = raddr[p*4 +: 4];
    if (!ren[p] || mbusy) return 32'h0;
    v = mreg[a];
    if (bp && m_accept() && a == waddr)
      v = (v & ~lane_mask(wen)) | (wdata & lane_mask(wen));
    return v;
  endfunction

  // Advance the model with the inputs currently driven, then cross one rising edge.
  task automatic tick();
    if (g_reset) begin
      for (int i = 0; i < NREGS; i++) mreg[i] = 32'h0;
      mbusy = 1'b0;
      mcnt  = 0;
    end else if (mbusy) begin
      mreg[mcnt] = 32'h0;
      if (mcnt == NREGS - 1) begin
        mbusy = 1'b0;
        mcnt  = 0;
      end else begin
        mcnt++;
      end
    end else if (wipe_req) begin
      mbusy = 1'b1;
      mcnt  = 0;
    end else if (m_accept()) begin
      mreg[waddr] = (mreg[waddr] & ~lane_mask(wen)) | (wdata & lane_mask(wen));
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_reads(input logic [2:0] r, input int a0, input int a1, input int a2);
    ren   = r;
    raddr = {4'(a2), 4'(a1), 4'(a0)};
  endtask

  task automatic push_reads();
    for (int p = 0; p < NRD; p++) begin
      sb.push_back('{port: p, bp: 1'b0, exp: m_read(p, 1'b0)});
      sb.push_back('{port: p, bp: 1'b1, exp: m_read(p, 1'b1)});
    end
  endtask

  task automatic drain_reads(input string tag);
    rd_exp_t     e;
    logic [31:0] act;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.bp ? rdata_bp[e.port*32 +: 32] : rdata[e.port*32 +: 32];
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s rdata port%0d bypass=%0d: got %h want %h", tag, e.port, e.bp, act, e.exp);
      end
    end
  endtask

  task automatic idle_inputs();
    wen = 4'h0; waddr = 4'h0; wdata = 32'h0; wipe_req = 1'b0;
    set_reads(3'b000, 0, 0, 0);
  endtask

  task automatic write_reg(input int a, input logic [31:0] d, input logic [3:0] w);
    wen = w; waddr = 4'(a); wdata = d;
    tick();
    wen = 4'h0;
  endtask

  task automatic fill_regs(input logic [31:0] seed);
    for (int i = 0; i < NREGS; i++) write_reg(i, seed ^ (32'h01010101 * (i + 1)), 4'hF);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NREGS; a++) begin
      set_reads(3'b111, a, a, a);
      push_reads();
      for (int p = 0; p < NRD; p++) sb.push_back('{port: p, bp: 1'b0, exp: 32'h0});
      drain_reads(tag);
    end
    set_reads(3'b000, 0, 0, 0);
  endtask

  task automatic check_flags(input string tag, input logic exp_busy, input logic exp_done);
    total++;
    if (busy !== exp_busy || busy_bp !== exp_busy) begin
      bad++;
      $display("FAIL %s wipe_busy: got %b/%b want %b", tag, busy, busy_bp, exp_busy);
    end
    total++;
    if (done !== exp_done || done_bp !== exp_done) begin
      bad++;
      $display("FAIL %s wipe_done: got %b/%b want %b", tag, done, done_bp, exp_done);
    end
  endtask

  task automatic count_wipe(input string tag, output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    set_reads(3'b111, 0, 0, 0);
    while (busy === 1'b1 && cycles < 40) begin
      set_reads(3'b111, cycles % NREGS, (cycles + 5) % NREGS, (cycles + 9) % NREGS);
      push_reads();
      drain_reads(tag);
      if (done === 1'b1) dones++;
      cycles++;
      tick();
    end
    set_reads(3'b000, 0, 0, 0);
  endtask

  task automatic test_reset();
    idle_inputs();
    g_reset = 1'b1;
    tick();
    tick();
    g_reset = 1'b0;
    #1;
    check_flags("reset", 1'b0, 1'b0);
    total++;
    if (clk_req !== 1'b0) begin
      bad++;
      $display("FAIL reset g_clk_req: got %b want 0", clk_req);
    end
    check_all_zero("reset_read");
  endtask

  task automatic test_write_merge();
    write_reg(5, 32'hDEADBEEF, 4'hF);
    wen = 4'h1; waddr = 4'd5; wdata = 32'h000000AA;
    #1;
    total++;
    if (clk_req !== 1'b1) begin
      bad++;
      $display("FAIL write g_clk_req: got %b want 1", clk_req);
    end
    tick();
    wen = 4'h0;
    set_reads(3'b011, 5, 5, 5);
    push_reads();
    drain_reads("write_merge");
    total++;
    if (rdata[31:0] !== 32'hDEADBEAA || rdata[95:64] !== 32'h0) begin
      bad++;
      $display("FAIL write_merge const: got %h/%h want deadbeaa/00000000", rdata[31:0], rdata[95:64]);
    end
    set_reads(3'b000, 0, 0, 0);
  endtask

  task automatic test_bypass();
    write_reg(3, 32'h11111111, 4'hF);
    wen = 4'h6; waddr = 4'd3; wdata = 32'h22334455;
    set_reads(3'b111, 3, 3, 3);
    push_reads();
    drain_reads("bypass_same_cycle");
    total++;
    if (rdata_bp[63:32] !== 32'h11334411 || rdata[63:32] !== 32'h11111111) begin
      bad++;
      $display("FAIL bypass const: got bp=%h nobp=%h want 11334411/11111111", rdata_bp[63:32], rdata[63:32]);
    end
    tick();
    wen = 4'h0;
    push_reads();
    drain_reads("bypass_next_cycle");
    set_reads(3'b000, 0, 0, 0);
  endtask

  task automatic test_wipe();
    int cycles, dones;
    fill_regs(32'hA5A55A5A);
    wipe_req = 1'b1;
    wen = 4'hF; waddr = 4'd2; wdata = 32'h55555555;
    tick();
    wipe_req = 1'b0;
    wen = 4'h0;
    total++;
    if (clk_req !== 1'b1) begin
      bad++;
      $display("FAIL wipe g_clk_req: got %b want 1", clk_req);
    end
    count_wipe("wipe_busy_read", cycles, dones);
    total++;
    if (cycles != NREGS) begin
      bad++;
      $display("FAIL wipe length: got %0d want %0d", cycles, NREGS);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL wipe_done pulses: got %0d want 1", dones);
    end
    check_flags("wipe_after", 1'b0, 1'b0);
    check_all_zero("wipe_after_read");
  endtask

  task automatic test_back_to_back();
    int cycles, dones;
    fill_regs(32'h3C3C3C3C);
    wipe_req = 1'b1;
    tick();
    wipe_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    wen = 4'hF; waddr = 4'd7; wdata = 32'h12345678; wipe_req = 1'b1;
    check_flags("collide_mid", 1'b1, 1'b0);
    tick();
    wen = 4'h0; wipe_req = 1'b0;
    count_wipe("collide_read", cycles, dones);
    total++;
    if (cycles != NREGS - 11) begin
      bad++;
      $display("FAIL collide remaining: got %0d want %0d", cycles, NREGS - 11);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL collide wipe_done pulses: got %0d want 1", dones);
    end
    set_reads(3'b111, 7, 7, 7);
    push_reads();
    drain_reads("collide_r7");
    total++;
    if (rdata[31:0] !== 32'h0) begin
      bad++;
      $display("FAIL collide r7 const: got %h want 00000000", rdata[31:0]);
    end
    set_reads(3'b000, 0, 0, 0);
  endtask

  task automatic test_reset_mid_wipe();
    int cycles, dones;
    fill_regs(32'hF0F00F0F);
    wipe_req = 1'b1;
    tick();
    wipe_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    check_flags("reset_mid", 1'b0, 1'b0);
    check_all_zero("reset_mid_read");
    fill_regs(32'h0F0F0F0F);
    wipe_req = 1'b1;
    tick();
    wipe_req = 1'b0;
    count_wipe("rewipe_read", cycles, dones);
    total++;
    if (cycles != NREGS || dones != 1) begin
      bad++;
      $display("FAIL rewipe: got cycles=%0d dones=%0d want %0d/1", cycles, dones, NREGS);
    end
    check_all_zero("rewipe_after");
  endtask

  initial begin
    g_reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < NREGS; i++) mreg[i] = 32'hX;
    mbusy = 1'b0;
    mcnt  = 0;
    test_reset();
    test_write_merge();
    test_bypass();
    test_wipe();
    test_back_to_back();
    test_reset_mid_wipe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
